gate_test_sequencer: RTL

//  Self-test controller for the basic_gates library. Walks a 2-input bitwise gate under test through every
//  {A,B} input combination, waits a settle window, samples X and checks it against the selected gate function.

---
 rtl/gate_seq_pkg.sv | 18 +
 rtl/gate_test_sequencer_expect.sv | 24 ++
 rtl/gate_test_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/gate_seq_pkg.sv
// Shared opcode and state encodings for the gate test sequencer.
package gate_seq_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_FIN    = 2'd3
    } state_e;

endpackage

// File: rtl/gate_test_sequencer_expect.sv
// Combinational reference for the selected 2-input bitwise gate.
module gate_expect
    import gate_seq_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_x
);

    always_comb begin
        o_x = '0;
        case (i_op)
            OP_AND:  o_x = i_a & i_b;
            OP_OR:   o_x = i_a | i_b;
            OP_XOR:  o_x = i_a ^ i_b;
            OP_NAND: o_x = ~(i_a & i_b);
            default: o_x = '0;
        endcase
    end

endmodule

// File: rtl/gate_test_sequencer.sv
// Self-test controller: walks a 2-input gate through all {A,B} vectors and counts mismatches.
// Optional first-failure capture ports are enabled by defining GATE_SEQ_FIRST_FAIL_EN.
module gate_test_sequencer
    import gate_seq_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op_sel,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    input  logic [WIDTH-1:0] i_x,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [1:0]       o_dbg_state
`ifdef GATE_SEQ_FIRST_FAIL_EN
    ,
    output logic             o_fail_vld,
    output logic [WIDTH-1:0] o_fail_a,
    output logic [WIDTH-1:0] o_fail_b
`endif
);

    localparam int VEC_W = 2 * WIDTH;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
    localparam logic [VEC_W-1:0] VEC_LAST    = '1;

    state_e             r_state;
    op_e                r_op;
    logic [VEC_W-1:0]   r_vec;
    logic [SET_W-1:0]   r_settle;
    logic [CNT_W-1:0]   r_err;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [WIDTH-1:0]   w_exp;
    logic               w_mismatch;
    logic [CNT_W-1:0]   w_err_next;
`ifdef GATE_SEQ_FIRST_FAIL_EN
    logic               r_fail_vld;
    logic [WIDTH-1:0]   r_fail_a;
    logic [WIDTH-1:0]   r_fail_b;
`endif

    // A is the upper half of the vector counter, so the sweep order is A-major.
    assign o_a         = r_vec[VEC_W-1:WIDTH];
    assign o_b         = r_vec[WIDTH-1:0];
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_err_cnt   = r_err;
    assign o_dbg_state = r_state;
`ifdef GATE_SEQ_FIRST_FAIL_EN
    assign o_fail_vld  = r_fail_vld;
    assign o_fail_a    = r_fail_a;
    assign o_fail_b    = r_fail_b;
`endif

    gate_expect #(.WIDTH(WIDTH)) u_expect (
        .i_op (r_op),
        .i_a  (o_a),
        .i_b  (o_b),
        .o_x  (w_exp)
    );

    // X is compared live in SAMPLE; the count saturates instead of wrapping.
    assign w_mismatch = (i_x != w_exp);
    assign w_err_next = (w_mismatch && (r_err != '1)) ? r_err + CNT_W'(1) : r_err;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= OP_AND;
            r_vec      <= '0;
            r_settle   <= '0;
            r_err      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
`ifdef GATE_SEQ_FIRST_FAIL_EN
            r_fail_vld <= 1'b0;
            r_fail_a   <= '0;
            r_fail_b   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_op       <= op_e'(i_op_sel);
                        r_err      <= '0;
                        r_pass     <= 1'b0;
                        r_vec      <= '0;
                        r_settle   <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_DRIVE;
`ifdef GATE_SEQ_FIRST_FAIL_EN
                        r_fail_vld <= 1'b0;
                        r_fail_a   <= '0;
                        r_fail_b   <= '0;
`endif
                    end
                end
                S_DRIVE: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_settle <= '0;
                        r_state  <= S_SAMPLE;
                    end else begin
                        r_settle <= r_settle + SET_W'(1);
                    end
                end
                S_SAMPLE: begin
                    r_err <= w_err_next;
`ifdef GATE_SEQ_FIRST_FAIL_EN
                    if (w_mismatch && !r_fail_vld) begin
                        r_fail_vld <= 1'b1;
                        r_fail_a   <= o_a;
                        r_fail_b   <= o_b;
                    end
`endif
                    // DONE/PASS/BUSY are registered on FIN entry so they are valid during FIN.
                    if (r_vec == VEC_LAST) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                        r_state <= S_FIN;
                    end else begin
                        r_vec   <= r_vec + VEC_W'(1);
                        r_state <= S_DRIVE;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
